// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-buffer entry type used by the instruction fetch unit.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO holding fetched {addr, inst} pairs; head is read straight from storage.
module ifu_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A pop frees the slot, so push is accepted at full occupancy when popping too.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches, buffers responses
// and hands them to IF/ID; a redirect flushes the buffer and drops every in-flight response.
module ifu_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [INST_W-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [XLEN-1:0]   jump_addr_i,
    input  logic              hold_i,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_fifo_cnt;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_credit_ok;
    logic            w_grant;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_out_next;

    // Buffered words plus in-flight fetches may never exceed the buffer size, so pushes never overflow.
    assign w_credit_ok = ({1'b0, w_fifo_cnt} + {1'b0, r_outstanding}) < (CW + 1)'(FIFO_DEPTH);
    assign mem_req_o   = rst & ~hold_i & ~jump_en_i & w_credit_ok;
    assign mem_addr_o  = r_pc;
    assign w_grant     = mem_req_o & mem_gnt_i;

    assign w_push      = mem_rvalid_i & ~jump_en_i & (r_drop == '0);
    assign w_pop       = inst_valid_o & inst_ready_i & ~jump_en_i;
    assign w_push_data = '{addr: r_rsp_pc, inst: mem_rdata_i};

    always_comb begin
        w_out_next = r_outstanding;
        if (w_grant)      w_out_next = w_out_next + CW'(1);
        if (mem_rvalid_i) w_out_next = w_out_next - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (jump_en_i) begin
                // Everything still in flight after this cycle belongs to the old stream.
                r_pc     <= word_align(jump_addr_i);
                r_rsp_pc <= word_align(jump_addr_i);
                r_drop   <= w_out_next;
            end else begin
                if (w_grant) r_pc <= r_pc + XLEN'(4);
                if (mem_rvalid_i) begin
                    if (r_drop != '0) r_drop   <= r_drop - CW'(1);
                    else              r_rsp_pc <= r_rsp_pc + XLEN'(4);
                end
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (jump_en_i),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_fifo_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign inst_valid_o = ~w_empty;
    assign inst_o       = w_empty ? NOP_INST : w_head.inst;
    assign inst_addr_o  = w_empty ? '0 : w_head.addr;

    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst)
        mem_rvalid_i |-> (r_outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        w_push |-> (!w_full || w_pop));

endmodule
